// File: rtl/shift_reg_univ.sv
// Universal N-bit shift register: direct per-edge operations plus a counted
// burst engine that repeats one shift mode n times with a busy/done handshake.
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] R,
    input  logic             wr,
    input  logic             wl,
    input  logic             start,
    input  logic [CW-1:0]    n,
    output logic [WIDTH-1:0] Q,
    output logic             so_r,
    output logic             so_l,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHR   = 3'b010;
    localparam logic [2:0] M_SHL   = 3'b011;
    localparam logic [2:0] M_ROR   = 3'b100;
    localparam logic [2:0] M_ROL   = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLR   = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       bmode_q, bmode_d;
    logic             done_q, done_d;

    // One step of the register for a given operation code.
    function automatic logic [WIDTH-1:0] step(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             sin_r,
        input logic             sin_l
    );
        logic [WIDTH-1:0] res;
        case (m)
            M_HOLD:  res = cur;
            M_LOAD:  res = ld;
            M_SHR:   res = {sin_r, cur[WIDTH-1:1]};
            M_SHL:   res = {cur[WIDTH-2:0], sin_l};
            M_ROR:   res = {cur[0], cur[WIDTH-1:1]};
            M_ROL:   res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ASR:   res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            M_CLR:   res = {WIDTH{1'b0}};
            default: res = cur;
        endcase
        return res;
    endfunction

    function automatic logic is_shift(input logic [2:0] m);
        return (m >= M_SHR) && (m <= M_ASR);
    endfunction

    // Next-state logic: direct operations in IDLE, counted repeats in RUN.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        bmode_d = bmode_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && is_shift(mode)) begin
                    state_d = RUN;
                    bmode_d = mode;
                    cnt_d   = n;
                end else begin
                    q_d = step(mode, q_q, R, wr, wl);
                end
            end
            RUN: begin
                // A zero count still spends one cycle in RUN before finishing.
                if (cnt_q != {CW{1'b0}}) begin
                    q_d   = step(bmode_q, q_q, R, wr, wl);
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            bmode_q <= M_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            bmode_q <= bmode_d;
            done_q  <= done_d;
        end
    end

    assign Q    = q_q;
    assign so_r = q_q[0];
    assign so_l = q_q[WIDTH-1];
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: directed test-plan steps followed by random
// traffic, all checked against an arithmetic reference model.
module tb_shift_reg_univ;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic [2:0]    mode;
    logic [W-1:0]  R;
    logic          wr;
    logic          wl;
    logic          start;
    logic [CW-1:0] n;
    logic [W-1:0]  Q;
    logic          so_r;
    logic          so_l;
    logic          busy;
    logic          done;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [W-1:0] eq     = 8'h00;
    logic         ebusy  = 1'b0;
    logic         edone  = 1'b0;
    int           erem   = 0;
    logic [2:0]   ebm    = 3'b000;

    shift_reg_univ #(.WIDTH(W), .CW(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode),
        .R     (R),
        .wr    (wr),
        .wl    (wl),
        .start (start),
        .n     (n),
        .Q     (Q),
        .so_r  (so_r),
        .so_l  (so_l),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] apply(input logic [2:0] m, input logic [W-1:0] q,
                                           input logic [W-1:0] ld, input logic si_r,
                                           input logic si_l);
        int v;
        v = int'(q);
        case (m)
            3'd0:    return q;
            3'd1:    return ld;
            3'd2:    return W'((v / 2) + (si_r ? 128 : 0));
            3'd3:    return W'(((v * 2) % 256) + (si_l ? 1 : 0));
            3'd4:    return W'((v / 2) + ((v % 2) * 128));
            3'd5:    return W'(((v * 2) % 256) + (v / 128));
            3'd6:    return W'((v / 2) + ((v >= 128) ? 128 : 0));
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one edge of stimulus, advance the model, then compare all outputs.
    task automatic tick(input string tag, input logic r, input logic [2:0] m,
                        input logic st, input logic [CW-1:0] nn, input logic [W-1:0] rv,
                        input logic wri, input logic wli);
        rst = r; mode = m; start = st; n = nn; R = rv; wr = wri; wl = wli;
        edone = 1'b0;
        if (r) begin
            eq = 8'h00; ebusy = 1'b0; erem = 0; ebm = 3'b000;
        end else if (ebusy) begin
            if (erem > 0) begin
                eq = apply(ebm, eq, rv, wri, wli);
                erem--;
            end
            if (erem == 0) begin
                ebusy = 1'b0;
                edone = 1'b1;
            end
        end else if (st && (m >= 3'd2) && (m <= 3'd6)) begin
            ebusy = 1'b1; ebm = m; erem = int'(nn);
        end else begin
            eq = apply(m, eq, rv, wri, wli);
        end
        @(posedge clk);
        #1;
        chk({tag, ".Q"}, Q, eq);
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, ebusy});
        chk({tag, ".done"}, {7'd0, done}, {7'd0, edone});
        chk({tag, ".so_r"}, {7'd0, so_r}, {7'd0, eq[0]});
        chk({tag, ".so_l"}, {7'd0, so_l}, {7'd0, eq[W-1]});
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        logic [2:0] modes [6];
        logic [W-1:0] plan [6];
        rst = 1'b1; mode = 3'd0; start = 1'b0; n = 4'd0; R = 8'h00; wr = 1'b0; wl = 1'b0;

        tick("reset", 1'b1, 3'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        chk("reset_q", Q, 8'h00);
        tick("load", 1'b0, 3'd1, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0);
        chk("load_q", Q, 8'hA5);
        for (int i = 0; i < 3; i++) tick("hold", 1'b0, 3'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        chk("hold_q", Q, 8'hA5);

        modes = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        plan  = '{8'hCB, 8'h2D, 8'h4B, 8'h2D, 8'hCB, 8'h00};
        for (int i = 0; i < 6; i++) begin
            tick("pre96", 1'b0, 3'd1, 1'b0, 4'd0, 8'h96, 1'b0, 1'b0);
            tick("mode1", 1'b0, modes[i], 1'b0, 4'd0, 8'h00, 1'b1, 1'b1);
            chk("plan_mode", Q, plan[i]);
        end

        // Rotate-right burst of 3 from 81 with mode flipped to clear mid-run
        tick("pre81", 1'b0, 3'd1, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0);
        tick("bstart", 1'b0, 3'd4, 1'b1, 4'd3, 8'h00, 1'b0, 1'b0);
        tick("brun1", 1'b0, 3'd7, 1'b1, 4'd9, 8'hFF, 1'b0, 1'b0);
        chk("burst1", Q, 8'hC0);
        tick("brun2", 1'b0, 3'd7, 1'b0, 4'd0, 8'hFF, 1'b0, 1'b0);
        chk("burst2", Q, 8'h60);
        tick("brun3", 1'b0, 3'd7, 1'b0, 4'd0, 8'hFF, 1'b0, 1'b0);
        chk("burst3", Q, 8'h30);
        chk("burst_done", {7'd0, done}, 8'h01);
        tick("bidle", 1'b0, 3'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        chk("burst_done_drop", {7'd0, done}, 8'h00);

        // n = 0: one busy cycle, Q unchanged
        tick("n0start", 1'b0, 3'd2, 1'b1, 4'd0, 8'h00, 1'b1, 1'b0);
        chk("n0_busy", {7'd0, busy}, 8'h01);
        tick("n0end", 1'b0, 3'd0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
        chk("n0_q", Q, 8'h30);

        // n = 10 shift-left of FF with wl=0
        tick("preFF", 1'b0, 3'd1, 1'b0, 4'd0, 8'hFF, 1'b0, 1'b0);
        tick("n10start", 1'b0, 3'd3, 1'b1, 4'd10, 8'h00, 1'b0, 1'b0);
        busy_cnt = 1;
        for (int i = 0; i < 12; i++) begin
            tick("n10run", 1'b0, 3'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
            if (busy) busy_cnt++;
        end
        chk("n10_q", Q, 8'h00);
        chk("n10_busy_cycles", 8'(busy_cnt), 8'd10);

        // Back-to-back bursts: second start in the done cycle
        tick("preB2B", 1'b0, 3'd1, 1'b0, 4'd0, 8'h5A, 1'b0, 1'b0);
        done_cnt = 0;
        tick("b2b_s1", 1'b0, 3'd2, 1'b1, 4'd2, 8'h00, 1'b0, 1'b0);
        tick("b2b_r1", 1'b0, 3'd2, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
        tick("b2b_r2", 1'b0, 3'd2, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        if (done) done_cnt++;
        tick("b2b_s2", 1'b0, 3'd2, 1'b1, 4'd2, 8'h00, 1'b1, 1'b0);
        chk("b2b_busy2", {7'd0, busy}, 8'h01);
        for (int i = 0; i < 4; i++) begin
            tick("b2b_run", 1'b0, 3'd0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
            if (done) done_cnt++;
        end
        chk("b2b_done_count", 8'(done_cnt), 8'd2);

        // Reset mid-burst
        tick("preRst", 1'b0, 3'd1, 1'b0, 4'd0, 8'hF0, 1'b0, 1'b0);
        tick("rst_s", 1'b0, 3'd4, 1'b1, 4'd5, 8'h00, 1'b0, 1'b0);
        tick("rst_r1", 1'b0, 3'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        tick("rst_r2", 1'b0, 3'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        tick("rst_hit", 1'b1, 3'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        chk("midrst_q", Q, 8'h00);
        tick("rst_after", 1'b0, 3'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        chk("midrst_nodone", {7'd0, done}, 8'h00);
        tick("rst_ld", 1'b0, 3'd1, 1'b0, 4'd0, 8'h03, 1'b0, 1'b0);
        tick("rst_s2", 1'b0, 3'd5, 1'b1, 4'd1, 8'h00, 1'b0, 1'b0);
        tick("rst_run", 1'b0, 3'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_burst", Q, 8'h06);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            tick("rand", ($urandom_range(0, 49) == 0),
                 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)), 8'($urandom),
                 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register with parallel load, bidirectional shift, rotate, arithmetic shift and clear, plus a counted burst-shift engine with a busy/done handshake. It is the general-purpose N-bit successor to the 4-bit load/shift-right register and sits wherever a datapath needs serialisation, alignment or multi-bit shifts under controller command.

## Interface
- WIDTH, 8, register width in bits (>= 2)
- CW, $clog2(WIDTH+1), width of the burst count input n

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  3  operation select (encoding below)
- R  in  WIDTH  parallel load data
- wr  in  1  serial input entering Q[WIDTH-1] on shift right
- wl  in  1  serial input entering Q[0] on shift left
- start  in  1  request a burst of n shifts using mode
- n  in  CW  burst shift count
- Q  out  WIDTH  register contents
- so_r  out  1  Q[0] (bit leaving on right shift)
- so_l  out  1  Q[WIDTH-1] (bit leaving on left shift)
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse: burst complete

## Operation
- Mode encoding (one edge = one step):
  - 000 hold
  - 001 load Q <= R
  - 010 shift right: Q[i] <= Q[i+1], Q[WIDTH-1] <= wr
  - 011 shift left: Q[i] <= Q[i-1], Q[0] <= wl
  - 100 rotate right: Q[WIDTH-1] <= Q[0]
  - 101 rotate left: Q[0] <= Q[WIDTH-1]
  - 110 arithmetic right: Q[WIDTH-1] unchanged
  - 111 clear Q <= 0
- Shift modes are 010-110. Priority per edge: rst > active burst > start > direct mode.
- FSM states: IDLE, RUN.
- IDLE, start=0: mode applied directly every edge.
- IDLE, start=1 with shift mode: latch mode into bmode, n into cnt, go RUN. Q not modified on that edge.
- IDLE, start=1 with non-shift mode (000/001/111): no burst; mode applied directly as if start=0.
- RUN, cnt>=1: apply bmode, cnt <= cnt-1. If cnt==1 -> IDLE, done <= 1.
- RUN, cnt==0 (n=0 requested): no shift -> IDLE, done <= 1.
- RUN: mode, start, R ignored. wr/wl sampled live each shift edge.
- n > WIDTH legal: performs exactly n steps (shift modes fill with serial/sign input; rotates wrap).
- busy = (state==RUN), combinational from state register. done is registered, high exactly one cycle.

## Timing
- Reset: Q=0, busy=0, done=0, state IDLE, cnt=0, bmode=000; synchronous, effective at the edge rst is sampled high.
- Reset mid-burst: aborts immediately, no done pulse, Q=0.
- Direct mode latency: 1 edge.
- Burst: start sampled at edge t0 -> busy=1 after t0. Shifts at edges t1..tn. After tn: busy=0, done=1. done cleared at tn+1.
- n=0: busy high for one cycle (t0..t1), done high after t1, Q unchanged.
- Back-to-back: start may be asserted in the cycle done is high (state IDLE). It is accepted at that edge; done still drops.
- so_r/so_l combinational from Q; no extra latency.

## Test plan
- Reset/direct: rst for 1 edge -> Q=00, busy=0, done=0. Load mode 001, R=A5 -> Q=A5 next cycle. Mode 000 for 3 edges -> Q stays A5.
- All modes one step from Q=96:
  - 010, wr=1 -> CB
  - 011, wl=1 -> 2D
  - 100 -> 4B
  - 101 -> 2D
  - 110 -> CB
  - 111 -> 00
- Burst: Q=81, start with mode 100, n=3 -> busy high 3 cycles. Q: 81 -> C0 -> 60 -> 30. done pulses once after third edge; mode changed to 111 during RUN has no effect.
- Edge counts:
  - n=0 -> busy 1 cycle, done 1 cycle, Q unchanged.
  - n=10, mode 011, wl=0, Q=FF -> Q=00 after 10 shifts, busy exactly 10 cycles.
- Back-to-back: start asserted in the done cycle with n=2, mode 010 -> second burst runs immediately. Exactly one done per burst.
- Reset mid-burst: start n=5, assert rst after 2 shifts -> Q=00, busy=0, no done pulse. Subsequent start works normally.
